// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, aluop and alucontrol values.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_alu_dec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to the
// 3-bit ALU operation select.
module alu_dec
  import mc_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALU_ADD;
          FUNCT_SUB: alucontrol_o = ALU_SUB;
          FUNCT_AND: alucontrol_o = ALU_AND;
          FUNCT_OR:  alucontrol_o = ALU_OR;
          FUNCT_SLT: alucontrol_o = ALU_SLT;
          default:   alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction, ALU
// decode, and PC enable gating from the branch condition.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       IorD,
  output logic       irwrite,
  output logic       pcen,
  output logic       memwrite,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StRtypeEx;
          OP_BEQ:       state_d = StBeqEx;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (op == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  // Under reset the outputs show FETCH values with every write enable held low.
  always_comb begin
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    aluop    = ALUOP_ADD;
    pcsrc    = PC_ALURES;
    IorD     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    unique case (reset ? StFetch : state_q)
      StFetch: begin
        alusrcb = SRCB_FOUR;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      StDecode: alusrcb = SRCB_IMMSH;
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      StMemRd: IorD = 1'b1;
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        memwrite = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      StRtypeWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBeqEx: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      StAddiWb: regwrite = 1'b1;
      StJEx: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      branch   = 1'b0;
    end
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

  alu_dec u_alu_dec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule
